// File: rtl/key_event_fifo_if.sv
// Key event handshake bundle: head event, valid/ready, merge pulse and FIFO occupancy.
// The producer (key_event_fifo) uses the master modport; the game FSM uses slave.
interface key_event_fifo_if #(
   parameter int unsigned LevelW = 3
);
   logic              evt_valid;
   logic              evt_ready;
   logic [4:0]        evt_code;
   logic              evt_drop;
   logic [LevelW-1:0] fifo_level;

   modport master (
      output evt_valid,
      output evt_code,
      output evt_drop,
      output fifo_level,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_code,
      input  evt_drop,
      input  fifo_level,
      output evt_ready
   );
endinterface

// File: rtl/key_event_fifo.sv
// Stability-filters 16 active-low key levels, turns new presses into queued key events.
// Define KEY_RELEASE_EVT_EN to also queue release events (evt_code[4]=1).
module key_event_fifo #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned STABLE_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      key_n,
   key_event_fifo_if.master evt
);

   localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CntW   = $clog2(STABLE_CYC + 1);

   function automatic logic [3:0] lowest_idx(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

   logic [15:0]       key_q;
   logic [CntW-1:0]   stab_cnt_q;
   logic [15:0]       filt_q;
   logic [15:0]       filt_prev_q;
   logic [15:0]       pend_q, pend_d;
   logic [4:0]        mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LevelW-1:0] level_q, level_d;
   logic              drop_q, drop_d;

   logic [15:0] press;
   logic [15:0] grant;
   logic [4:0]  grant_code;
   logic        full;
   logic        push;
   logic        pop;

`ifdef KEY_RELEASE_EVT_EN
   logic [15:0] pend_rel_q, pend_rel_d;
   logic [15:0] release_edge;
   logic [15:0] grant_rel;
`endif

   assign evt.evt_valid  = (level_q != '0);
   assign evt.evt_code   = evt.evt_valid ? mem_q[rd_ptr_q] : 5'd0;
   assign evt.evt_drop   = drop_q;
   assign evt.fifo_level = level_q;

   assign pop = evt.evt_valid && evt.evt_ready;

   always_comb begin
      press      = filt_prev_q & ~filt_q;
      full       = (level_q == LevelW'(FIFO_DEPTH));
      grant      = '0;
      grant_code = '0;
      push       = 1'b0;
`ifdef KEY_RELEASE_EVT_EN
      release_edge = ~filt_prev_q & filt_q;
      grant_rel    = '0;
`endif
      // Full blocks the push even if a pop frees a slot this cycle.
      if (!full) begin
         if (pend_q != '0) begin
            grant      = 16'd1 << lowest_idx(pend_q);
            grant_code = {1'b0, lowest_idx(pend_q)};
            push       = 1'b1;
         end
`ifdef KEY_RELEASE_EVT_EN
         else if (pend_rel_q != '0) begin
            grant_rel  = 16'd1 << lowest_idx(pend_rel_q);
            grant_code = {1'b1, lowest_idx(pend_rel_q)};
            push       = 1'b1;
         end
`endif
      end

      // A new edge on an already-pending, ungranted bit collapses into one event.
      pend_d = (pend_q & ~grant) | press;
      drop_d = |(press & pend_q & ~grant);
`ifdef KEY_RELEASE_EVT_EN
      pend_rel_d = (pend_rel_q & ~grant_rel) | release_edge;
      drop_d     = drop_d | (|(release_edge & pend_rel_q & ~grant_rel));
`endif

      case ({push, pop})
         2'b10:   level_d = level_q + LevelW'(1);
         2'b01:   level_d = level_q - LevelW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         key_q       <= 16'hFFFF;
         stab_cnt_q  <= '0;
         filt_q      <= 16'hFFFF;
         filt_prev_q <= 16'hFFFF;
         pend_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         drop_q      <= 1'b0;
      end else begin
         key_q       <= key_n;
         filt_prev_q <= filt_q;
         if (key_n != key_q) begin
            stab_cnt_q <= '0;
         end else begin
            if (stab_cnt_q != CntW'(STABLE_CYC)) stab_cnt_q <= stab_cnt_q + CntW'(1);
            if (stab_cnt_q == CntW'(STABLE_CYC - 1)) filt_q <= key_q;
         end
         pend_q  <= pend_d;
         level_q <= level_d;
         drop_q  <= drop_d;
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
   end

   // Storage needs no reset: the head is masked to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (!rst && push) mem_q[wr_ptr_q] <= grant_code;
   end

`ifdef KEY_RELEASE_EVT_EN
   always_ff @(posedge clk) begin
      if (rst) pend_rel_q <= '0;
      else     pend_rel_q <= pend_rel_d;
   end
`endif

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed plus random bench for key_event_fifo against a queue-based event model.
module tb_key_event_fifo;
   localparam int unsigned Depth  = 4;
   localparam int unsigned Stable = 2;
   localparam int unsigned LevelW = $clog2(Depth) + 1;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] key_n;

   key_event_fifo_if #(.LevelW(LevelW)) evt ();

   key_event_fifo #(.FIFO_DEPTH(Depth), .STABLE_CYC(Stable)) dut (
      .clk   (clk),
      .rst   (rst),
      .key_n (key_n),
      .evt   (evt)
   );

   always #10 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Model: filt takes a key_n value once it has been sampled Stable+1 times in a row.
   logic [15:0] m_last;
   int          m_run;
   logic [15:0] m_filt, m_filt_prev, m_pend, m_pend_rel;
   logic        m_drop;
   logic [4:0]  m_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_last      = 16'hFFFF;
      m_run       = 1;
      m_filt      = 16'hFFFF;
      m_filt_prev = 16'hFFFF;
      m_pend      = '0;
      m_pend_rel  = '0;
      m_drop      = 1'b0;
      m_q.delete();
   endtask

   task automatic model_edge();
      logic [15:0] press, gmask;
      logic [4:0]  gcode;
      bit          do_push, do_pop;
`ifdef KEY_RELEASE_EVT_EN
      logic [15:0] rel, gmask_rel;
`endif
      if (rst) begin
         model_reset();
         return;
      end
      press   = m_filt_prev & ~m_filt;
      gmask   = '0;
      gcode   = '0;
      do_push = 1'b0;
      do_pop  = (m_q.size() != 0) && evt.evt_ready;
`ifdef KEY_RELEASE_EVT_EN
      rel       = ~m_filt_prev & m_filt;
      gmask_rel = '0;
`endif
      if (m_q.size() < Depth) begin
         for (int i = 0; i < 16; i++) begin
            if (m_pend[i]) begin
               gmask[i] = 1'b1;
               gcode    = 5'(i);
               do_push  = 1'b1;
               break;
            end
         end
`ifdef KEY_RELEASE_EVT_EN
         if (!do_push) begin
            for (int i = 0; i < 16; i++) begin
               if (m_pend_rel[i]) begin
                  gmask_rel[i] = 1'b1;
                  gcode        = 5'(16 + i);
                  do_push      = 1'b1;
                  break;
               end
            end
         end
`endif
      end
      m_drop = |(press & m_pend & ~gmask);
      m_pend = (m_pend & ~gmask) | press;
`ifdef KEY_RELEASE_EVT_EN
      m_drop     = m_drop | (|(rel & m_pend_rel & ~gmask_rel));
      m_pend_rel = (m_pend_rel & ~gmask_rel) | rel;
`endif
      if (do_pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(gcode);
      m_filt_prev = m_filt;
      if (key_n == m_last) begin
         if (m_run < 1000) m_run++;
      end else begin
         m_last = key_n;
         m_run  = 1;
      end
      if (m_run >= Stable + 1) m_filt = key_n;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("valid", evt.evt_valid, (m_q.size() != 0));
      chk("code", evt.evt_code, (m_q.size() != 0) ? m_q[0] : 5'd0);
      chk("level", evt.fifo_level, m_q.size());
      chk("drop", evt.evt_drop, m_drop);
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      logic [4:0] exp4 [3];
      logic [4:0] exp5 [6];
      logic [4:0] seen [$];
      int         hold;

      exp4 = '{5'd2, 5'd9, 5'd14};
      exp5 = '{5'd0, 5'd1, 5'd4, 5'd8, 5'd11, 5'd15};
      model_reset();
      rst           = 1'b1;
      key_n         = 16'hFFDF;
      evt.evt_ready = 1'b0;

      // Reset with a key held, then release key and reset together.
      settle(3);
      chk("t1_valid", evt.evt_valid, 1'b0);
      chk("t1_code", evt.evt_code, 5'd0);
      chk("t1_level", evt.fifo_level, 0);
      chk("t1_drop", evt.evt_drop, 1'b0);
      rst   = 1'b0;
      key_n = 16'hFFFF;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("t1_noevt", evt.evt_valid, 1'b0);
      end

      // Single press of key 5 with the consumer ready.
      evt.evt_ready = 1'b1;
      key_n         = 16'hFFDF;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("t2_valid", evt.evt_valid, (k == 4));
         if (k == 4) chk("t2_code", evt.evt_code, 5'd5);
      end
      chk("t2_level", evt.fifo_level, 0);
      key_n = 16'hFFFF;
      settle(8);

      // One-clock bounce on key 3.
      key_n = 16'hFFF7;
      step();
      key_n = 16'hFFFF;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("t3_noevt", evt.evt_valid, 1'b0);
      end

      // Keys 9, 2, 14 together with backpressure.
      evt.evt_ready = 1'b0;
      key_n         = ~16'h4204;
      for (int k = 0; k < 7; k++) begin
         step();
         if (k >= 4) chk("t4_level", evt.fifo_level, k - 3);
      end
      evt.evt_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("t4_code", evt.evt_code, exp4[i]);
         step();
      end
      chk("t4_empty", evt.evt_valid, 1'b0);
      key_n = 16'hFFFF;
      settle(12);

      // Six presses into a four-entry FIFO.
      evt.evt_ready = 1'b0;
      key_n         = ~16'h8913;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("t5_nodrop", evt.evt_drop, 1'b0);
      end
      chk("t5_full", evt.fifo_level, 4);
      evt.evt_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         chk("t5_code", evt.evt_code, exp5[i]);
         chk("t5_nodrop", evt.evt_drop, 1'b0);
         step();
      end
      chk("t5_empty", evt.evt_valid, 1'b0);
      key_n = 16'hFFFF;
      settle(20);

      // Press and release key 7.
      key_n = 16'hFF7F;
      for (int k = 0; k < 16; k++) begin
         if (k == 6) key_n = 16'hFFFF;
         step();
         if (evt.evt_valid) seen.push_back(evt.evt_code);
      end
`ifdef KEY_RELEASE_EVT_EN
      chk("t6_count", seen.size(), 2);
      if (seen.size() == 2) chk("t6_rel", seen[1], 5'h17);
`else
      chk("t6_count", seen.size(), 1);
`endif
      if (seen.size() >= 1) chk("t6_press", seen[0], 5'h07);

      // Random key activity, backpressure bursts and occasional reset.
      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 79) == 0) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
         end
         key_n         = key_n ^ 16'($urandom & $urandom & $urandom);
         evt.evt_ready = ($urandom_range(0, 2) != 0);
         hold          = $urandom_range(1, 4);
         for (int h = 0; h < hold; h++) step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
